ins_encoder: RTL and testbench

//  Packs decoded instruction fields (op enum, rs/rt/rd, 32-bit immediate value) into 32-bit MIPS words.

---
 rtl/ins_pkg.sv | 111 +++++++++++
 rtl/ins_field_pack.sv | 59 +++++
 rtl/ins_encoder.sv | 107 ++++++++++
 tb/tb_ins_encoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_pkg.sv
// Shared types and encodings for the instruction encoder.
// Op enum, MIPS opcode/funct tables, error codes, FSM states.
package ins_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
    OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_SLL, OP_SRL,
    OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
    OP_JR, OP_ADDI, OP_ADDIU, OP_ANDI,
    OP_ORI, OP_XORI, OP_LW, OP_SW,
    OP_BEQ, OP_BNE, OP_SLTI, OP_SLTIU,
    OP_LUI, OP_J, OP_JAL
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE, S_WRITE, S_DONE, S_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_OP    = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [5:0] OC_ADDI  = 6'h08;
  localparam logic [5:0] OC_ADDIU = 6'h09;
  localparam logic [5:0] OC_ANDI  = 6'h0c;
  localparam logic [5:0] OC_ORI   = 6'h0d;
  localparam logic [5:0] OC_XORI  = 6'h0e;
  localparam logic [5:0] OC_LW    = 6'h23;
  localparam logic [5:0] OC_SW    = 6'h2b;
  localparam logic [5:0] OC_BEQ   = 6'h04;
  localparam logic [5:0] OC_BNE   = 6'h05;
  localparam logic [5:0] OC_SLTI  = 6'h0a;
  localparam logic [5:0] OC_SLTIU = 6'h0b;
  localparam logic [5:0] OC_LUI   = 6'h0f;
  localparam logic [5:0] OC_J     = 6'h02;
  localparam logic [5:0] OC_JAL   = 6'h03;

  function automatic logic [5:0] funct_of(
    input logic [4:0] op
  );
    logic [5:0] f;
    f = 6'h00;
    case (op)
      OP_ADD:  f = FN_ADD;
      OP_ADDU: f = FN_ADDU;
      OP_SUB:  f = FN_SUB;
      OP_SUBU: f = FN_SUBU;
      OP_AND:  f = FN_AND;
      OP_OR:   f = FN_OR;
      OP_XOR:  f = FN_XOR;
      OP_NOR:  f = FN_NOR;
      OP_SLT:  f = FN_SLT;
      OP_SLTU: f = FN_SLTU;
      OP_SLL:  f = FN_SLL;
      OP_SRL:  f = FN_SRL;
      OP_SRA:  f = FN_SRA;
      OP_SLLV: f = FN_SLLV;
      OP_SRLV: f = FN_SRLV;
      OP_SRAV: f = FN_SRAV;
      OP_JR:   f = FN_JR;
      default: f = 6'h00;
    endcase
    return f;
  endfunction

  function automatic logic [5:0] opcode_of(
    input logic [4:0] op
  );
    logic [5:0] c;
    c = 6'h00;
    case (op)
      OP_ADDI:  c = OC_ADDI;
      OP_ADDIU: c = OC_ADDIU;
      OP_ANDI:  c = OC_ANDI;
      OP_ORI:   c = OC_ORI;
      OP_XORI:  c = OC_XORI;
      OP_LW:    c = OC_LW;
      OP_SW:    c = OC_SW;
      OP_BEQ:   c = OC_BEQ;
      OP_BNE:   c = OC_BNE;
      OP_SLTI:  c = OC_SLTI;
      OP_SLTIU: c = OC_SLTIU;
      OP_LUI:   c = OC_LUI;
      OP_J:     c = OC_J;
      OP_JAL:   c = OC_JAL;
      default:  c = 6'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ins_field_pack.sv
// Combinational field packer: op + fields -> MIPS word.
// Immediates are checked so re-extension yields the input value.
module ins_field_pack
  import ins_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic [1:0]  err
);

  logic [5:0] fn;
  logic [5:0] oc;
  logic       sext_ok;

  assign fn = funct_of(op);
  assign oc = opcode_of(op);
  assign sext_ok = (imm[31:15] == '0)
                 | (imm[31:15] == '1);

  always_comb begin
    word = '0;
    err  = ERR_NONE;
    case (op)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
      OP_AND, OP_OR, OP_XOR, OP_NOR,
      OP_SLT, OP_SLTU, OP_SLLV, OP_SRLV,
      OP_SRAV:
        word = {6'b0, rs, rt, rd, 5'b0, fn};
      OP_SLL, OP_SRL, OP_SRA:
        if (|imm[31:5]) err = ERR_RANGE;
        else word = {6'b0, rs, rt, rd,
                     imm[4:0], fn};
      OP_JR:
        word = {6'b0, rs, 15'b0, fn};
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU:
        if (!sext_ok) err = ERR_RANGE;
        else word = {oc, rs, rt, imm[15:0]};
      OP_ANDI, OP_ORI, OP_XORI,
      OP_LW, OP_SW, OP_LUI:
        if (|imm[31:16]) err = ERR_RANGE;
        else word = {oc, rs, rt, imm[15:0]};
      OP_BEQ, OP_BNE:
        if (|imm[1:0]) err = ERR_ALIGN;
        else if (|imm[31:18]) err = ERR_RANGE;
        else word = {oc, rs, rt, imm[17:2]};
      // top nibble is the PC region, supplied at jump time
      OP_J, OP_JAL:
        if (|imm[1:0]) err = ERR_ALIGN;
        else word = {oc, imm[27:2]};
      default:
        err = ERR_OP;
    endcase
  end

endmodule

// File: rtl/ins_encoder.sv
// Instruction encoder: packs field bundles and streams
// the words into instruction memory, one per two cycles.
module ins_encoder
  import ins_pkg::*;
#(
  parameter int              ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] pk_word;
  logic [1:0]  pk_err;
  logic        accept;
  logic        fail;
  logic        last;

  ins_field_pack u_pack (
    .op   (op),
    .rs   (rs),
    .rt   (rt),
    .rd   (rd),
    .imm  (imm),
    .word (pk_word),
    .err  (pk_err)
  );

  assign in_ready = (state_q == S_IDLE);
  assign last     = (im_addr == '1);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fail    = 1'b0;
    if (start) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (in_valid) begin
            if (pk_err != ERR_NONE) begin
              fail    = 1'b1;
              state_d = S_ERR;
            end else begin
              accept  = 1'b1;
              state_d = S_WRITE;
            end
          end
        S_WRITE:
          state_d = last ? S_DONE : S_IDLE;
        S_DONE:  state_d = S_DONE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      im_we    <= 1'b0;
      im_addr  <= BASE;
      im_wdata <= '0;
      full     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state_q <= state_d;
      im_we   <= accept;
      if (accept) im_wdata <= pk_word;
      if (start) begin
        im_addr  <= BASE;
        full     <= 1'b0;
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end else begin
        // no wrap: the last slot parks the pointer
        if (state_q == S_WRITE) begin
          if (last) full <= 1'b1;
          else im_addr <= im_addr + 1'b1;
        end
        if (fail) begin
          err      <= 1'b1;
          err_code <= pk_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_ins_encoder.sv
// Randomized bench for ins_encoder against an
// arithmetic reference of the MIPS field layout.
module tb_ins_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st1 = 1'b0;
  logic        st2 = 1'b0;
  logic        vld1 = 1'b0;
  logic        vld2 = 1'b0;
  logic [4:0]  op = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [4:0]  rd = '0;
  logic [31:0] imm = '0;

  logic        rdy1, we1, full1, err1;
  logic [9:0]  addr1;
  logic [31:0] wd1;
  logic [1:0]  code1;
  logic        rdy2, we2, full2, err2;
  logic [1:0]  addr2;
  logic [31:0] wd2;
  logic [1:0]  code2;

  int total = 0;
  int bad   = 0;
  logic sel = 1'b0;
  int m_addr [2];
  logic m_full [2];

  always #5 clk = ~clk;

  ins_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(st1),
    .in_valid(vld1), .in_ready(rdy1),
    .op(op), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .im_we(we1), .im_addr(addr1),
    .im_wdata(wd1), .full(full1),
    .err(err1), .err_code(code1)
  );

  ins_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2),
    .in_valid(vld2), .in_ready(rdy2),
    .op(op), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .im_we(we2), .im_addr(addr2),
    .im_wdata(wd2), .full(full2),
    .err(err2), .err_code(code2)
  );

  logic        c_rdy, c_we, c_full, c_err;
  logic [31:0] c_addr, c_wd;
  logic [1:0]  c_code;
  assign c_rdy  = sel ? rdy2 : rdy1;
  assign c_we   = sel ? we2 : we1;
  assign c_full = sel ? full2 : full1;
  assign c_err  = sel ? err2 : err1;
  assign c_addr = sel ? 32'(addr2) : 32'(addr1);
  assign c_wd   = sel ? wd2 : wd1;
  assign c_code = sel ? code2 : code1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] ref_enc(
    input int o, input int s, input int t,
    input int d, input logic [31:0] i);
    int fn_t [17] = '{32, 33, 34, 35, 36, 37,
      38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8};
    int oc_t [14] = '{8, 9, 12, 13, 14, 35,
      43, 4, 5, 10, 11, 15, 2, 3};
    logic [31:0] w, oc, base;
    longint si;
    int c;
    w = 0;
    c = 0;
    si = longint'($signed(i));
    if (o == 31) c = 1;
    else if (o <= 16) begin
      if (o >= 10 && o <= 12 && i > 31) c = 2;
      else if (o == 16) w = s * 2**21 + 8;
      else begin
        w = s * 2**21 + t * 2**16 + d * 2**11
          + fn_t[o];
        if (o >= 10 && o <= 12) w = w + i * 64;
      end
    end else begin
      oc = oc_t[o-17];
      base = oc * 2**26 + s * 2**21 + t * 2**16;
      if (o inside {17, 18, 26, 27}) begin
        if (si < -32768 || si > 32767) c = 2;
        else w = base + (i % 65536);
      end else if (o inside {19, 20, 21, 22, 23, 28})
      begin
        if (i > 65535) c = 2;
        else w = base + i;
      end else if (o inside {24, 25}) begin
        if (i % 4 != 0) c = 3;
        else if (i >= 2**18) c = 2;
        else w = base + i / 4;
      end else begin
        if (i % 4 != 0) c = 3;
        else w = oc * 2**26 + (i / 4) % 2**26;
      end
    end
    return {c[1:0], w};
  endfunction

  task automatic send(input int o, input int s,
                      input int t, input int d,
                      input logic [31:0] i);
    logic [33:0] r;
    int n, maxa;
    r = ref_enc(o, s, t, d, i);
    maxa = sel ? 3 : 1023;
    n = 0;
    while (!c_rdy && n < 10) begin
      tick();
      n++;
    end
    if (!c_rdy) begin
      chk("rdy_timeout", 32'(c_rdy), 1);
      return;
    end
    op = 5'(o); rs = 5'(s); rt = 5'(t);
    rd = 5'(d); imm = i;
    if (sel) vld2 = 1'b1;
    else vld1 = 1'b1;
    tick();
    vld1 = 1'b0;
    vld2 = 1'b0;
    if (r[33:32] != 2'd0) begin
      chk("we_on_err", 32'(c_we), 0);
      chk("err", 32'(c_err), 1);
      chk("err_code", 32'(c_code), 32'(r[33:32]));
      chk("rdy_on_err", 32'(c_rdy), 0);
    end else begin
      chk("we", 32'(c_we), 1);
      chk("addr", c_addr, m_addr[sel]);
      chk("wdata", c_wd, r[31:0]);
      tick();
      chk("we_off", 32'(c_we), 0);
      if (m_addr[sel] == maxa) m_full[sel] = 1'b1;
      else m_addr[sel]++;
      chk("addr_next", c_addr, m_addr[sel]);
      chk("full", 32'(c_full), 32'(m_full[sel]));
      chk("rdy", 32'(c_rdy), 32'(!m_full[sel]));
    end
  endtask

  task automatic do_start();
    if (sel) st2 = 1'b1;
    else st1 = 1'b1;
    tick();
    st1 = 1'b0;
    st2 = 1'b0;
    m_addr[sel] = 0;
    m_full[sel] = 1'b0;
    chk("st_err", 32'(c_err), 0);
    chk("st_code", 32'(c_code), 0);
    chk("st_rdy", 32'(c_rdy), 1);
    chk("st_addr", c_addr, 0);
    chk("st_full", 32'(c_full), 0);
  endtask

  function automatic logic [31:0] rnd_imm();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = 32'($urandom_range(0, 40));
      1: v = 32'hFFFF_7FF0
           + 32'($urandom_range(0, 32'h1_0020));
      2: v = 32'($urandom_range(0, 32'h1_0004)) << 2;
      3: v = $urandom;
      default: v = 32'($urandom_range(0, 32'h1_0010));
    endcase
    return v;
  endfunction

  initial begin
    logic [33:0] r;
    int o;
    logic [31:0] iv;
    m_addr = '{0, 0};
    m_full = '{1'b0, 1'b0};
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_we", 32'(we1), 0);
    chk("rst_addr", 32'(addr1), 0);
    chk("rst_wdata", wd1, 0);
    chk("rst_full", 32'(full1), 0);
    chk("rst_err", 32'(err1), 0);
    chk("rst_code", 32'(code1), 0);
    chk("rst_rdy", 32'(rdy1), 1);

    sel = 1'b0;
    send(0, 1, 2, 3, 32'h0);
    send(17, 1, 2, 0, 32'hFFFF_FFFF);
    send(10, 0, 5, 4, 32'd3);
    send(24, 1, 2, 0, 32'h10);
    send(29, 0, 0, 0, 32'h0040_0010);
    send(16, 7, 9, 11, 32'h0);

    send(24, 1, 2, 0, 32'h6);
    op = 5'd31;
    vld1 = 1'b1;
    tick();
    vld1 = 1'b0;
    chk("sticky_code", 32'(code1), 3);
    chk("sticky_we", 32'(we1), 0);
    do_start();

    send(20, 0, 0, 0, 32'h0001_0000);
    do_start();
    send(31, 0, 0, 0, 32'h0);
    do_start();
    send(12, 1, 1, 1, 32'd32);
    do_start();
    send(28, 3, 4, 0, 32'h0000_FFFF);
    send(26, 3, 4, 0, 32'hFFFF_8000);
    send(27, 3, 4, 0, 32'hFFFF_7FFF);
    do_start();

    for (int k = 0; k < 250; k++) begin
      o = $urandom_range(0, 31);
      iv = rnd_imm();
      r = ref_enc(o, 0, 0, 0, iv);
      send(o, $urandom_range(0, 31),
           $urandom_range(0, 31),
           $urandom_range(0, 31), iv);
      if (r[33:32] != 2'd0) do_start();
    end

    sel = 1'b1;
    for (int k = 0; k < 4; k++)
      send($urandom_range(0, 9), k, k + 1, k + 2, 0);
    tick();
    chk("full_hold", 32'(full2), 1);
    chk("full_rdy", 32'(rdy2), 0);
    chk("full_addr", 32'(addr2), 3);
    do_start();
    send(0, 1, 2, 3, 32'h0);

    sel = 1'b0;
    op = 5'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3;
    vld1 = 1'b1;
    tick();
    vld1 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_we", 32'(we1), 0);
    chk("mid_rst_addr", 32'(addr1), 0);
    chk("mid_rst_wdata", wd1, 0);
    chk("mid_rst_err", 32'(err1), 0);
    chk("mid_rst_full", 32'(full1), 0);
    chk("mid_rst_rdy", 32'(rdy1), 1);
    tick();
    chk("mid_rst_we2", 32'(we1), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
